posit_to_int_slave: RTL and testbench
=====================================

POSIT_TO_INT_SLAVE -- requirements
Module: posit_to_int_slave

Interface
REQ-001 Parameter N, default 8: output integer width, unsigned.
REQ-002 Parameter PS, default 16: posit width.
REQ-003 Parameter ES, default 0: posit exponent bits; only ES=0 is supported.
REQ-004 Parameter D, default 8: input FIFO depth in words.
REQ-005 Parameter D_S, default 3: FIFO pointer width, log2(D).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pipe_read_data  input  PS  posit word from the upstream int_to_posit_master.
REQ-009 pipe_read_req  input  1  upstream has a valid word on pipe_read_data.
REQ-010 pipe_read_ack  output  1  block can accept a word this cycle.
REQ-011 tx_axis_tvalid  output  1  AXI-Stream valid.
REQ-012 tx_axis_tdata  output  N  AXI-Stream data, converted unsigned integer.
REQ-013 tx_axis_tready  input  1  AXI-Stream ready from downstream.

Function
REQ-014 pipe_read_ack SHALL be high whenever the FIFO holds fewer than D words, independent of pipe_read_req.
REQ-015 A word SHALL be accepted on every edge where pipe_read_req and pipe_read_ack are both high; upstream may hold req high for back-to-back words.
REQ-016 The FIFO SHALL be first-word-fall-through, depth D, with wrap-around read/write pointers of D_S bits and a D_S+1-bit occupancy count.
REQ-017 On an edge with both a push and a pop, occupancy SHALL be unchanged; when full, a push with a simultaneous pop SHALL NOT occur because ack is low.
REQ-018 The datapath SHALL have two registered stages: S1 (decode) and S2 (output register driving tx_axis_tdata and tx_axis_tvalid).
REQ-019 S1 SHALL take the FIFO head word when S1 is empty or S1 advances into S2.
REQ-020 S1 SHALL register the sign, regime k from the leading run length, and the fraction bits.
REQ-021 S2 SHALL load from S1 when S2 is empty or tx_axis_tready is high.
REQ-022 S2 SHALL compute value = 2^k x 1.f, rounded to nearest with ties to even.
REQ-023 Special cases in S2:
  - 0x0000 -> 0
  - NaR (0x8000) -> 0
  - any negative posit -> 0
  - any value >= 255.5 (2^N - 0.5) -> 2^N - 1, saturating
REQ-024 Latency: a word accepted at edge E with the pipeline empty and tready high SHALL appear with tvalid high in the cycle after edge E+2.
REQ-025 Throughput SHALL be one word per cycle while req and tready are continuously high.
REQ-026 tx_axis_tvalid SHALL stay high and tx_axis_tdata stable until an edge with tready high (AXI rule); no bubbles SHALL be inserted while S1 is full.
REQ-027 With tready low, S1 and S2 SHALL hold and the FIFO SHALL fill; ack SHALL drop on the edge that makes occupancy D.
REQ-028 Output order SHALL equal input order; no word SHALL be dropped or duplicated.

Reset
REQ-029 While reset is high at an edge:
  - FIFO pointers and count -> 0
  - S1 and S2 valid -> 0
  - tx_axis_tvalid -> 0
  - tx_axis_tdata -> 0
  - pipe_read_ack -> 0
REQ-030 In the first cycle after reset deasserts, pipe_read_ack SHALL be 1.
REQ-031 Reset mid-stream SHALL discard all buffered and in-flight words, and no partial word SHALL be emitted afterwards.

Verification
REQ-032 Conversion, tready=1, req held high with words 0x7900, 0x4000, 0x6400, 0x6C00, 0x3000, 0x2000 -> tdata sequence 10, 1, 2, 4, 1, 0, starting 2 cycles after the first accept.
REQ-033 Specials and saturation: 0x0000, 0x8000, 0xC000, 0x7FFF -> 0, 0, 0, 255.
REQ-034 Backpressure: tready=0 with req held high -> exactly D=8 accepts to fill the FIFO, plus 2 more held in S1/S2, then ack=0. Raising tready -> all 10 words out in order, with no gaps and no loss.
REQ-035 Simultaneous push/pop at occupancy 7 (one below full) for 20 cycles -> count stays 7 and ack stays 1. Pointers wrap past 7 to 0 and data stays correct.
REQ-036 Reset asserted for 1 cycle while 5 words are buffered and tvalid=1 -> next cycle tvalid=0 and count=0. The following cycle ack=1, and the next accepted word 0x4000 -> 1 with normal latency.
REQ-037 AXI stability: tready toggling every cycle -> tdata never changes while tvalid=1 and tready=0.

Source files
------------

// File: rtl/posit_to_int_slave_if.sv
// Handshake bundle between the upstream posit pipe, the converter and the
// downstream AXI-Stream sink.
interface posit_to_int_slave_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned PS = 16
);
    logic [PS-1:0] pipe_read_data;
    logic          pipe_read_req;
    logic          pipe_read_ack;
    logic          tx_axis_tvalid;
    logic [N-1:0]  tx_axis_tdata;
    logic          tx_axis_tready;

    modport slave (
        input  pipe_read_data,
        input  pipe_read_req,
        input  tx_axis_tready,
        output pipe_read_ack,
        output tx_axis_tvalid,
        output tx_axis_tdata
    );

    modport master (
        output pipe_read_data,
        output pipe_read_req,
        output tx_axis_tready,
        input  pipe_read_ack,
        input  tx_axis_tvalid,
        input  tx_axis_tdata
    );
endinterface

// File: rtl/posit_to_int_slave.sv
// Posit (es=0) to unsigned integer converter: FWFT input FIFO, a decode stage
// (S1) and a rounding/saturating output register (S2) feeding AXI-Stream.
module posit_to_int_slave #(
    parameter int unsigned N   = 8,
    parameter int unsigned PS  = 16,
    parameter int unsigned ES  = 0,
    parameter int unsigned D   = 8,
    parameter int unsigned D_S = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    posit_to_int_slave_if.slave  bus_io
);
    // Fraction bits left after sign, shortest regime (2 bits) and exponent.
    localparam int unsigned F  = PS - 3 - ES;
    localparam int unsigned KW = $clog2(PS) + 1;
    // Integer part (N+1 bits) above a guard bit and F sticky bits.
    localparam int unsigned W  = F + N + 2;

    logic [PS-1:0]         mem_q [D];
    logic [D_S-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [D_S:0]          count_q, count_d;
    logic                  ack_q, ack_d;
    logic                  s1_v_q, s1_v_d;
    logic                  s1_zero_q, s1_zero_d;
    logic signed [KW-1:0]  s1_k_q, s1_k_d;
    logic [F-1:0]          s1_frac_q, s1_frac_d;
    logic                  tvalid_q, tvalid_d;
    logic [N-1:0]          tdata_q, tdata_d;

    logic                  push, pop, s2_adv;
    logic [PS-1:0]         head;
    logic [PS-2:0]         body;
    logic [KW-1:0]         run;
    logic                  stop;
    logic                  zero_dec;
    logic signed [KW-1:0]  k_dec;
    logic [F-1:0]          frac_dec;
    logic [KW-1:0]         k1;
    logic [W-1:0]          y;
    logic [N:0]            ip, sum;
    logic                  rnd;
    logic [N-1:0]          conv;

    function automatic logic [D_S-1:0] ptr_inc(input logic [D_S-1:0] p);
        return (p == D_S'(D - 1)) ? '0 : p + D_S'(1);
    endfunction

    // Decode the FIFO head: regime run length, k and left-aligned fraction.
    always_comb begin
        head = mem_q[rd_ptr_q];
        body = head[PS-2:0];
        run  = '0;
        stop = 1'b0;
        for (int i = PS - 2; i >= 0; i--) begin
            if (!stop && body[i] == body[PS-2]) run = run + KW'(1);
            else stop = 1'b1;
        end
        k_dec    = body[PS-2] ? $signed(run - KW'(1)) : -$signed(run);
        // Drop the run and its terminator; what remains is the fraction.
        frac_dec = F'(((body << run) << 1) >> (PS - 1 - F));
        // Negative posits and NaR share the sign bit and all map to 0.
        zero_dec = head[PS-1] | ~|body;
    end

    // Scale 1.f by 2^k, round half to even, saturate at 2^N-1.
    always_comb begin
        k1   = s1_k_q + KW'(1);
        y    = W'({1'b1, s1_frac_q}) << k1;
        ip   = y[W-1 -: N+1];
        rnd  = y[F] & ((|y[F-1:0]) | ip[0]);
        sum  = ip + (N+1)'(rnd);
        if (s1_zero_q || int'(s1_k_q) < -1) conv = '0;
        else if (int'(s1_k_q) >= int'(N) || sum[N]) conv = '1;
        else conv = sum[N-1:0];
    end

    // Next state for FIFO control, S1 and S2.
    always_comb begin
        s2_adv   = ~tvalid_q | bus_io.tx_axis_tready;
        pop      = (count_q != '0) & (~s1_v_q | s2_adv);
        push     = bus_io.pipe_read_req & ack_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (D_S+1)'(1);
            2'b01:   count_d = count_q - (D_S+1)'(1);
            default: count_d = count_q;
        endcase
        ack_d = count_d < (D_S+1)'(D);

        s1_v_d    = s1_v_q;
        s1_zero_d = s1_zero_q;
        s1_k_d    = s1_k_q;
        s1_frac_d = s1_frac_q;
        if (pop) begin
            s1_v_d    = 1'b1;
            s1_zero_d = zero_dec;
            s1_k_d    = k_dec;
            s1_frac_d = frac_dec;
        end else if (s2_adv) begin
            s1_v_d = 1'b0;
        end

        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (s2_adv) begin
            tvalid_d = s1_v_q;
            if (s1_v_q) tdata_d = conv;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_k_q    <= '0;
            s1_frac_q <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            s1_v_q    <= s1_v_d;
            s1_zero_q <= s1_zero_d;
            s1_k_q    <= s1_k_d;
            s1_frac_q <= s1_frac_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_io.pipe_read_data;
    end

    assign bus_io.pipe_read_ack  = ack_q;
    assign bus_io.tx_axis_tvalid = tvalid_q;
    assign bus_io.tx_axis_tdata  = tdata_q;
endmodule

// File: tb/tb_posit_to_int_slave.sv
// Directed bench for posit_to_int_slave with a real-arithmetic reference model
// and a scoreboard checked on every output handshake.
module tb_posit_to_int_slave;
    localparam int unsigned N  = 8;
    localparam int unsigned PS = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;
    bit   toggle = 1'b0;
    bit   held = 1'b0;
    int   held_data = 0;
    int   first_acc_cyc = -1;
    int   n_acc;
    int   exp_q[$];
    int   got[$];
    int   got_cyc[$];
    logic [15:0] words[$];

    posit_to_int_slave_if #(.N(N), .PS(PS)) bus ();

    posit_to_int_slave #(.N(N), .PS(PS), .ES(0), .D(8), .D_S(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (toggle) begin
            #1;
            bus.tx_axis_tready = ~bus.tx_axis_tready;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: value = 2^k * (1 + f), round half to even, clamp to 2^N-1.
    function automatic int model(input logic [15:0] p);
        int  run;
        int  k;
        real v;
        real fl;
        real d;
        int  r;
        if (p[15] || p == 16'h0000) return 0;
        run = 1;
        while (run < 15 && p[14-run] == p[14]) run++;
        k = p[14] ? run - 1 : -run;
        v = 1.0;
        for (int b = 13 - run; b >= 0; b--) begin
            if (p[b]) v = v + 1.0 / real'(1 << ((14 - run) - b));
        end
        if (k >= 0) begin
            for (int j = 0; j < k; j++) v = v * 2.0;
        end else begin
            for (int j = 0; j < -k; j++) v = v / 2.0;
        end
        if (v >= real'(1 << N) - 0.5) return (1 << N) - 1;
        fl = $floor(v);
        d  = v - fl;
        r  = $rtoi(fl);
        if (d > 0.5 || (d == 0.5 && (r % 2) == 1)) r++;
        return r;
    endfunction

    // Scoreboard, AXI hold check and acceptance tracking, away from the edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("axi_hold_valid", int'(bus.tx_axis_tvalid), 1);
                chk("axi_hold_data", int'(bus.tx_axis_tdata), held_data);
            end
            if (bus.tx_axis_tvalid && bus.tx_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    chk("scoreboard", int'(bus.tx_axis_tdata), exp_q.pop_front());
                end
                got.push_back(int'(bus.tx_axis_tdata));
                got_cyc.push_back(cyc);
            end
            held      = bus.tx_axis_tvalid && !bus.tx_axis_tready;
            held_data = int'(bus.tx_axis_tdata);
            if (bus.pipe_read_req && bus.pipe_read_ack)
                exp_q.push_back(model(bus.pipe_read_data));
        end
    end

    // Offer words[] with req high; called and returning just after a rising edge.
    task automatic drive(input int max_cyc, input bit ack_each, output int acc);
        int i = 0;
        for (int c = 0; c < max_cyc && i < words.size(); c++) begin
            bus.pipe_read_data = words[i];
            bus.pipe_read_req  = 1'b1;
            @(negedge clk);
            if (ack_each) chk("ack_held_high", int'(bus.pipe_read_ack), 1);
            if (bus.pipe_read_ack) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
                i++;
            end
            @(posedge clk);
            #1;
        end
        bus.pipe_read_req = 1'b0;
        acc = i;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int c = 0;
        while (got.size() < n && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(name, got.size(), n);
    endtask

    task automatic start_phase();
        got.delete();
        got_cyc.delete();
        first_acc_cyc = -1;
    endtask

    initial begin : main
        int exp_conv[6] = '{10, 1, 2, 4, 1, 0};
        int exp_spec[4] = '{0, 0, 0, 255};
        int exp_bp[10]  = '{10, 1, 2, 4, 1, 0, 0, 0, 0, 255};
        int exp_tog[8]  = '{10, 4, 0, 255, 1, 2, 1, 0};

        reset = 1'b1;
        bus.pipe_read_req  = 1'b0;
        bus.pipe_read_data = '0;
        bus.tx_axis_tready = 1'b1;

        // Model pins
        chk("model_7900", model(16'h7900), 10);
        chk("model_6400", model(16'h6400), 2);
        chk("model_2000", model(16'h2000), 0);
        chk("model_7FFF", model(16'h7FFF), 255);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", int'(bus.pipe_read_ack), 0);
        chk("rst_tvalid", int'(bus.tx_axis_tvalid), 0);
        chk("rst_tdata", int'(bus.tx_axis_tdata), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_after_reset", int'(bus.pipe_read_ack), 1);
        @(posedge clk);
        #1;

        // Conversion, latency and throughput
        start_phase();
        words = '{16'h7900, 16'h4000, 16'h6400, 16'h6C00, 16'h3000, 16'h2000};
        drive(20, 1'b0, n_acc);
        chk("conv_accepts", n_acc, 6);
        wait_outputs(6, "conv_count");
        for (int i = 0; i < 6; i++) chk($sformatf("conv_word%0d", i), got[i], exp_conv[i]);
        chk("conv_latency", got_cyc[0] - first_acc_cyc, 2);
        chk("conv_no_gaps", got_cyc[5] - got_cyc[0], 5);

        // Specials and saturation
        start_phase();
        words = '{16'h0000, 16'h8000, 16'hC000, 16'h7FFF};
        drive(20, 1'b0, n_acc);
        wait_outputs(4, "spec_count");
        for (int i = 0; i < 4; i++) chk($sformatf("spec_word%0d", i), got[i], exp_spec[i]);

        // Backpressure: FIFO plus both stages fill, then drain without gaps
        start_phase();
        bus.tx_axis_tready = 1'b0;
        words = '{16'h7900, 16'h4000, 16'h6400, 16'h6C00, 16'h3000, 16'h2000,
                  16'h0000, 16'h8000, 16'hC000, 16'h7FFF, 16'h4000, 16'h4000};
        drive(20, 1'b0, n_acc);
        chk("bp_accepts", n_acc, 10);
        @(negedge clk);
        chk("bp_ack_low", int'(bus.pipe_read_ack), 0);
        chk("bp_tvalid", int'(bus.tx_axis_tvalid), 1);
        @(posedge clk);
        #1 bus.tx_axis_tready = 1'b1;
        wait_outputs(10, "bp_count");
        for (int i = 0; i < 10; i++) chk($sformatf("bp_word%0d", i), got[i], exp_bp[i]);
        chk("bp_no_gaps", got_cyc[9] - got_cyc[0], 9);

        // Steady push+pop one below full, pointers wrapping
        start_phase();
        bus.tx_axis_tready = 1'b0;
        words.delete();
        for (int i = 0; i < 9; i++) words.push_back(16'h4400 + 16'(i) * 16'h0700);
        drive(20, 1'b0, n_acc);
        chk("occ7_fill", n_acc, 9);
        bus.tx_axis_tready = 1'b1;
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(16'h2000 + 16'(i) * 16'h04F1);
        drive(20, 1'b1, n_acc);
        chk("occ7_accepts", n_acc, 20);
        wait_outputs(29, "occ7_count");

        // Mid-stream reset discards everything
        start_phase();
        bus.tx_axis_tready = 1'b0;
        words = '{16'h7900, 16'h6400, 16'h6C00, 16'h7FFF, 16'h3000};
        drive(10, 1'b0, n_acc);
        chk("rst_fill", n_acc, 5);
        @(negedge clk);
        chk("rst_pre_tvalid", int'(bus.tx_axis_tvalid), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", int'(bus.tx_axis_tvalid), 0);
        chk("midrst_tdata", int'(bus.tx_axis_tdata), 0);
        chk("midrst_ack", int'(bus.pipe_read_ack), 0);
        @(negedge clk);
        chk("midrst_ack_next", int'(bus.pipe_read_ack), 1);
        @(posedge clk);
        #1 bus.tx_axis_tready = 1'b1;
        start_phase();
        words = '{16'h4000};
        drive(10, 1'b0, n_acc);
        wait_outputs(1, "midrst_out");
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_only_one", got.size(), 1);
        chk("midrst_value", got[0], 1);
        chk("midrst_latency", got_cyc[0] - first_acc_cyc, 2);

        // tready toggling every cycle
        start_phase();
        toggle = 1'b1;
        words = '{16'h7900, 16'h6C00, 16'h0000, 16'h7FFF, 16'h4000, 16'h6400,
                  16'h3000, 16'h2000};
        drive(40, 1'b0, n_acc);
        wait_outputs(8, "tog_count");
        toggle = 1'b0;
        @(posedge clk);
        #2 bus.tx_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) chk($sformatf("tog_word%0d", i), got[i], exp_tog[i]);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
